// File: rtl/arith_pkg.sv
// Shared definitions for the serial adder/subtractor family.
package arith_pkg;

  // Default operand width used across the family.
  localparam int unsigned DefaultWidth = 4;

  // Sequencer states for the bit-serial arithmetic units.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } arith_state_e;

endpackage

// File: rtl/fsubtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module fsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generation for a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = x - y - bin, LSB first,
// one full-subtractor cell plus a registered borrow, start/busy/done handshake.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  arith_state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CntW-1:0]  cnt;
  logic             br;
  logic             xs, ys;
  logic             cell_d, cell_bout;

  fsubtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only honoured in idle, done lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Serial datapath and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      xs   <= 1'b0;
      ys   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      busy <= (state_d == StShift);
      done <= (state_q == StDone);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sr <= x;
            b_sr <= y;
            br   <= bin;
            cnt  <= '0;
            xs   <= x[WIDTH-1];
            ys   <= y[WIDTH-1];
          end
        end
        StShift: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= {cell_d, r_sr[WIDTH-1:1]};
          br   <= cell_bout;
          cnt  <= cnt + 1'b1;
        end
        StDone: begin
          diff <= r_sr;
          bout <= br;
          // Overflow only possible when operand signs differ.
          ovf  <= (xs != ys) && (r_sr[WIDTH-1] != xs);
          zero <= (r_sr == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
